// File: rtl/mod_unit.sv
// Iterative unsigned remainder unit (alu_src1 % alu_src2) for ALU mux input 7.
// Restoring shift-subtract, one quotient bit per clock; quotient itself is discarded.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; outputs hold last result
// CALC  | iterating, one shift-subtract step per edge, busy high
// DONE  | result valid, done high for one cycle; start here is accepted
module mod_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] alu_src1,
    input  logic [WIDTH-1:0] alu_src2,
    output logic [WIDTH-1:0] mod_res,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] divisor_q;
    logic [CNT_W-1:0] count_q;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             rem_fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // The restored remainder is always below the divisor, so it fits in WIDTH
    // bits; only the shifted trial value needs the extra bit. The borrow out of
    // the WIDTH+1 bit subtraction is exactly the "R < divisor" condition.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, divisor_q};
        rem_fits  = ~rem_diff[WIDTH];
        rem_next  = rem_fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {quo_q[WIDTH-2:0], rem_fits};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            count_q   <= '0;
            mod_res   <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (alu_src2 == '0) begin
                            mod_res  <= alu_src1;
                            div_zero <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            divisor_q <= alu_src2;
                            quo_q     <= alu_src1;
                            rem_q     <= '0;
                            count_q   <= '0;
                            div_zero  <= 1'b0;
                            state     <= ST_CALC;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    rem_q   <= rem_next;
                    quo_q   <= quo_next;
                    count_q <= count_q + CNT_W'(1);
                    if (count_q == LAST_ITER) begin
                        mod_res  <= rem_next;
                        div_zero <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_CALC);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mod_unit.sv
// Self-checking bench for mod_unit: directed scenarios plus randomized operands
// compared against a plain '%' reference model.
module tb_mod_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] mod_res;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_checks;
    int n_pass;

    mod_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .alu_src1 (alu_src1),
        .alu_src2 (alu_src2),
        .mod_res  (mod_res),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mod(input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) ? a : (a % b);
    endfunction

    // Issue one operation; must be called between edges. Returns after done is seen
    // (or a timeout). lat = edges after the accepting edge until done is high.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic dz,
                          output int lat, output int bcnt, output logic tmo);
        alu_src1 = a;
        alu_src2 = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        alu_src1 = $urandom;
        alu_src2 = $urandom;
        lat  = 0;
        bcnt = 0;
        tmo  = 1'b0;
        while (!done) begin
            if (busy) bcnt++;
            if (lat >= 100) begin
                tmo = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
            alu_src1 = $urandom;
            alu_src2 = $urandom;
        end
        res = mod_res;
        dz  = div_zero;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        start    = 1'b0;
        alu_src1 = 32'h1234_5678;
        alu_src2 = 32'h0000_0003;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({mod_res, busy, done, div_zero} !== 35'd0)
            $display("FAIL reset_outputs: got %h/%b/%b/%b expected 0/0/0/0", mod_res, busy, done, div_zero);
        else n_pass++;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({mod_res, busy, done, div_zero} !== 35'd0)
                $display("FAIL idle_outputs[%0d]: got %h/%b/%b/%b expected 0/0/0/0", i, mod_res, busy, done, div_zero);
            else n_pass++;
        end
    endtask

    task automatic test_basic;
        logic [31:0] ta [4] = '{32'd100, 32'hFFFF_FFFF, 32'd3,  32'h8000_0000};
        logic [31:0] tb [4] = '{32'd7,   32'h0000_0010, 32'd10, 32'hFFFF_FFFF};
        logic [31:0] te [4] = '{32'd2,   32'h0000_000F, 32'd3,  32'h8000_0000};
        logic [31:0] res;
        logic dz, tmo;
        int lat, bcnt;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], res, dz, lat, bcnt, tmo);
            n_checks++;
            if (tmo) $display("FAIL basic_timeout[%0d]: got no done expected done", i);
            else n_pass++;
            n_checks++;
            if (res !== te[i]) $display("FAIL basic_result[%0d]: got %h expected %h", i, res, te[i]);
            else n_pass++;
            n_checks++;
            if (dz !== 1'b0) $display("FAIL basic_div_zero[%0d]: got %b expected 0", i, dz);
            else n_pass++;
            n_checks++;
            if (lat !== 32) $display("FAIL basic_latency[%0d]: got %0d expected 32", i, lat);
            else n_pass++;
            n_checks++;
            if (bcnt !== 32) $display("FAIL basic_busy_cycles[%0d]: got %0d expected 32", i, bcnt);
            else n_pass++;
            @(posedge clk);
            #1;
            n_checks++;
            if (done !== 1'b0 || mod_res !== te[i])
                $display("FAIL basic_done_pulse[%0d]: got done=%b res=%h expected done=0 res=%h", i, done, mod_res, te[i]);
            else n_pass++;
        end
    endtask

    task automatic test_div_zero;
        logic [31:0] res;
        logic dz, tmo;
        int lat, bcnt;
        run_op(32'd5, 32'd0, res, dz, lat, bcnt, tmo);
        n_checks++;
        if (res !== 32'd5 || dz !== 1'b1)
            $display("FAIL dz_result: got %h dz=%b expected 00000005 dz=1", res, dz);
        else n_pass++;
        n_checks++;
        if (lat !== 0 || bcnt !== 0 || tmo)
            $display("FAIL dz_timing: got lat=%0d busy=%0d expected lat=0 busy=0", lat, bcnt);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || div_zero !== 1'b1)
            $display("FAIL dz_hold: got done=%b dz=%b expected done=0 dz=1", done, div_zero);
        else n_pass++;
        run_op(32'd9, 32'd4, res, dz, lat, bcnt, tmo);
        n_checks++;
        if (res !== 32'd1 || dz !== 1'b0 || lat !== 32)
            $display("FAIL dz_followup: got %h dz=%b lat=%0d expected 00000001 dz=0 lat=32", res, dz, lat);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_busy;
        int n_done, done_edge;
        logic [31:0] res;
        alu_src1 = 32'd50;
        alu_src2 = 32'd8;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_done = 0;
        done_edge = -1;
        res = 32'hDEAD_BEEF;
        for (int e = 1; e <= 45; e++) begin
            if (e == 10) begin
                alu_src1 = 32'd99;
                alu_src2 = 32'd5;
                start    = 1'b1;
            end else begin
                start    = 1'b0;
                alu_src1 = $urandom;
                alu_src2 = $urandom_range(3, 0);
            end
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                done_edge = e;
                res = mod_res;
            end
        end
        start = 1'b0;
        n_checks++;
        if (n_done !== 1) $display("FAIL busy_done_count: got %0d expected 1", n_done);
        else n_pass++;
        n_checks++;
        if (res !== 32'd2 || done_edge !== 32)
            $display("FAIL busy_result: got %h at edge %0d expected 00000002 at edge 32", res, done_edge);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] res;
        logic dz, tmo;
        int lat, bcnt;
        alu_src1 = 32'd1000;
        alu_src2 = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (17) @(posedge clk);
        #2;
        n_checks++;
        if (busy !== 1'b1 || mod_res !== 32'd2)
            $display("FAIL mid_pre_reset: got busy=%b res=%h expected busy=1 res=00000002", busy, mod_res);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mod_res, busy, done, div_zero} !== 35'd0)
            $display("FAIL mid_reset_clear: got %h/%b/%b/%b expected 0/0/0/0", mod_res, busy, done, div_zero);
        else n_pass++;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        run_op(32'd1000, 32'd7, res, dz, lat, bcnt, tmo);
        n_checks++;
        if (res !== 32'd6 || lat !== 32 || bcnt !== 32 || tmo)
            $display("FAIL mid_rerun: got %h lat=%0d busy=%0d expected 00000006 lat=32 busy=32", res, lat, bcnt);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] pa [3] = '{32'd17, 32'd0, 32'd8};
        logic [31:0] pb [3] = '{32'd5,  32'd3, 32'd0};
        logic [31:0] pe [3] = '{32'd2,  32'd0, 32'd8};
        logic        pz [3] = '{1'b0,   1'b0,  1'b1};
        int          pt [3] = '{33,     66,    67};
        int k;
        k = 0;
        alu_src1 = pa[0];
        alu_src2 = pb[0];
        start    = 1'b1;
        for (int e = 1; e <= 150 && k < 3; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_checks++;
                if (mod_res !== pe[k] || div_zero !== pz[k] || e !== pt[k])
                    $display("FAIL b2b[%0d]: got %h dz=%b edge=%0d expected %h dz=%b edge=%0d",
                             k, mod_res, div_zero, e, pe[k], pz[k], pt[k]);
                else n_pass++;
                k++;
                if (k < 3) begin
                    alu_src1 = pa[k];
                    alu_src2 = pb[k];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (k !== 3) $display("FAIL b2b_count: got %0d done pulses expected 3", k);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        logic [31:0] a, b, exp_res, res;
        logic dz, tmo;
        int lat, bcnt, errs;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom >> $urandom_range(31, 0);
            if ($urandom_range(9, 0) == 0) b = 32'd0;
            else begin
                b = $urandom >> $urandom_range(31, 0);
                if (b == 32'd0) b = 32'd1;
            end
            exp_res = ref_mod(a, b);
            run_op(a, b, res, dz, lat, bcnt, tmo);
            n_checks++;
            if (res !== exp_res || dz !== (b == 32'd0) || tmo) begin
                if (errs < 10)
                    $display("FAIL rand_result[%0d]: %h %% %h got %h dz=%b expected %h dz=%b",
                             i, a, b, res, dz, exp_res, (b == 32'd0));
                errs++;
            end else n_pass++;
            n_checks++;
            if (lat !== ((b == 32'd0) ? 0 : 32)) begin
                if (errs < 10)
                    $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, (b == 32'd0) ? 0 : 32);
                errs++;
            end else n_pass++;
            if ($urandom_range(1, 0) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        alu_src1 = '0;
        alu_src2 = '0;
        test_reset();
        test_basic();
        test_div_zero();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
